// File: rtl/pio_access_arbiter.sv
// pio_access_arbiter: round-robin two-requester arbiter serialising single-cycle PIO slave accesses
module pio_access_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          ack,
   output logic [DATA_W-1:0]   rdata,
   output logic                busy,
   output logic [ADDR_W-1:0]   pio_address,
   output logic                pio_chipselect,
   output logic                pio_write_n,
   output logic [DATA_W-1:0]   pio_writedata,
   input  logic [DATA_W-1:0]   pio_readdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_nxt;
   logic grant, last_grant, grant_nxt, we_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   // On contention the requester that did not win last time gets the slot
   assign grant_nxt = (req == 2'b11) ? ~last_grant : req[1];
   // State register; reset abandons any in-flight access at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end
   // Next-state: one fixed IDLE -> ACCESS -> RESP loop per request
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = |req ? ACCESS : IDLE;
         ACCESS:  state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end
   // Latch the winner's fields in IDLE, capture slave data in ACCESS, record the winner in RESP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         we_l       <= 1'b0;
         addr_l     <= '0;
         wdata_l    <= '0;
         rdata      <= '0;
      end else begin
         if (state == IDLE && |req) begin
            grant   <= grant_nxt;
            we_l    <= grant_nxt ? we[1] : we[0];
            addr_l  <= grant_nxt ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            wdata_l <= grant_nxt ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
         end
         if (state == ACCESS) rdata <= pio_readdata;
         if (state == RESP) last_grant <= grant;
      end
   end
   // Outputs decoded from state so reset clears strobes without waiting for a clock
   always_comb begin
      pio_chipselect = (state == ACCESS);
      pio_write_n    = ~((state == ACCESS) & we_l);
      pio_address    = addr_l;
      pio_writedata  = wdata_l;
      busy           = (state != IDLE);
      ack            = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   end
endmodule

// File: tb/tb_pio_access_arbiter.sv
// tb_pio_access_arbiter: directed checks of the PIO arbiter against a behavioural PIO slave
module tb_pio_access_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = '0, we = '0, ack;
   logic [3:0]  addr = '0;
   logic [63:0] wdata = '0;
   logic [31:0] rdata, pio_writedata, pio_readdata;
   logic [1:0]  pio_address;
   logic        busy, pio_chipselect, pio_write_n;
   logic [31:0] slave_reg = '0;
   logic [31:0] exp_reg = '0;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   pio_access_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .pio_address(pio_address),
      .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
      .pio_writedata(pio_writedata), .pio_readdata(pio_readdata)
   );

   // PIO output register slave: only address 0 is implemented
   always @(posedge clk)
      if (pio_chipselect && !pio_write_n && pio_address == 2'd0) slave_reg <= pio_writedata;
   assign pio_readdata = (pio_address == 2'd0) ? slave_reg : 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated transaction from requester i; exp_rd is the slave value seen during ACCESS
   task automatic txn(input int i, input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
      @(negedge clk);
      req = 2'b01 << i;
      we[i] = w;
      addr[i*2 +: 2] = a;
      wdata[i*32 +: 32] = d;
      chk({tag, " cs@N"}, {31'd0, pio_chipselect}, 32'd0);
      @(negedge clk);
      chk({tag, " cs@N+1"}, {31'd0, pio_chipselect}, 32'd1);
      chk({tag, " write_n@N+1"}, {31'd0, pio_write_n}, {31'd0, ~w});
      chk({tag, " addr@N+1"}, {30'd0, pio_address}, {30'd0, a});
      chk({tag, " wdata@N+1"}, pio_writedata, d);
      chk({tag, " ack@N+1"}, {30'd0, ack}, 32'd0);
      chk({tag, " busy@N+1"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, " ack@N+2"}, {30'd0, ack}, {30'd0, 2'b01 << i});
      chk({tag, " rdata@N+2"}, rdata, exp_rd);
      chk({tag, " cs@N+2"}, {31'd0, pio_chipselect}, 32'd0);
      chk({tag, " slave@N+2"}, slave_reg, exp_reg);
      req = 2'b00;
      @(negedge clk);
      chk({tag, " ack@N+3"}, {30'd0, ack}, 32'd0);
      chk({tag, " busy@N+3"}, {31'd0, busy}, 32'd0);
      chk({tag, " addr hold"}, {30'd0, pio_address}, {30'd0, a});
   endtask

   initial begin
      #2;
      chk("rst cs", {31'd0, pio_chipselect}, 32'd0);
      chk("rst write_n", {31'd0, pio_write_n}, 32'd1);
      chk("rst ack", {30'd0, ack}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst addr", {30'd0, pio_address}, 32'd0);
      chk("rst wdata", pio_writedata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      exp_reg = 32'hDEADBEEF;
      txn(0, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0, "wr0");
      exp_reg = 32'h12345678;
      txn(0, 1'b1, 2'd0, 32'h12345678, 32'hDEADBEEF, "wr0b");
      txn(1, 1'b0, 2'd0, 32'h0, 32'h12345678, "rd1");

      // R1 drops req during ACCESS; the ack still comes and nothing is re-granted
      @(negedge clk);
      req = 2'b10; we = 2'b00; addr = 4'b0000;
      @(negedge clk);
      req = 2'b00;
      chk("drop cs", {31'd0, pio_chipselect}, 32'd1);
      @(negedge clk);
      chk("drop ack", {30'd0, ack}, 32'd2);
      chk("drop rdata", rdata, 32'h12345678);
      @(negedge clk);
      chk("drop idle busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("drop no regrant cs", {31'd0, pio_chipselect}, 32'd0);
      chk("drop no regrant ack", {30'd0, ack}, 32'd0);

      txn(0, 1'b1, 2'd2, 32'hFFFFFFFF, 32'h0, "unused wr");
      txn(0, 1'b0, 2'd2, 32'h0, 32'h0, "unused rd");

      // Reset in the middle of an R0 write in ACCESS
      @(negedge clk);
      req = 2'b01; we = 2'b01; addr = 4'b0000; wdata = {32'h0, 32'hAAAA5555};
      @(negedge clk);
      chk("rstacc cs before", {31'd0, pio_chipselect}, 32'd1);
      reset_n = 1'b0;
      req = 2'b00;
      #1;
      chk("rstacc cs", {31'd0, pio_chipselect}, 32'd0);
      chk("rstacc write_n", {31'd0, pio_write_n}, 32'd1);
      chk("rstacc ack", {30'd0, ack}, 32'd0);
      chk("rstacc busy", {31'd0, busy}, 32'd0);
      chk("rstacc rdata", rdata, 32'd0);
      @(negedge clk);
      chk("rstacc slave kept", slave_reg, 32'h12345678);
      chk("rstacc ack later", {30'd0, ack}, 32'd0);
      reset_n = 1'b1;

      // Continuous contention: R0 first after reset, then strict alternation every 3 cycles
      @(negedge clk);
      req = 2'b11; we = 2'b11; addr = 4'b0000; wdata = {32'h2, 32'h1};
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk($sformatf("cont%0d cs", t), {31'd0, pio_chipselect}, 32'd1);
         chk($sformatf("cont%0d wdata", t), pio_writedata, (t % 2 == 0) ? 32'h1 : 32'h2);
         @(negedge clk);
         chk($sformatf("cont%0d ack", t), {30'd0, ack}, (t % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("cont%0d rdata", t), rdata, exp_reg);
         exp_reg = (t % 2 == 0) ? 32'h1 : 32'h2;
         chk($sformatf("cont%0d slave", t), slave_reg, exp_reg);
         @(negedge clk);
         chk($sformatf("cont%0d idle ack", t), {30'd0, ack}, 32'd0);
         chk($sformatf("cont%0d idle busy", t), {31'd0, busy}, 32'd0);
      end
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("end busy", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/pio_access_arbiter.md
# pio_access_arbiter

Two-requester round-robin arbiter and access sequencer in front of the 32-bit Avalon-MM PIO output register slave. It lets the Nios data master (requester 0) and a hardware command engine (requester 1) share the PIO. Each access is a req/ack transaction, serialised into exactly one single-cycle chipselect access on the PIO slave. Read data from the slave is returned with the ack.

## Interface
Parameters:
- DATA_W, 32, data width of the PIO slave and of each requester.
- ADDR_W, 2, word address width of the PIO slave.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester request; held high until the matching ack.
- we  in  2  per-requester write enable (1 = write, 0 = read); valid while req is high.
- addr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- wdata  in  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
- ack  out  2  one-cycle completion pulse for the granted requester.
- rdata  out  DATA_W  read data captured from the slave; valid in the ack cycle and held until the next capture.
- busy  out  1  high in the ACCESS and RESP states.
- pio_address  out  ADDR_W  slave address.
- pio_chipselect  out  1  slave chipselect.
- pio_write_n  out  1  slave write strobe, active-low.
- pio_writedata  out  DATA_W  slave write data.
- pio_readdata  in  DATA_W  slave read data; zero-wait, combinational in the address.

## Operation
- State machine:
  - IDLE: if req is nonzero, choose the grant, latch that requester's we/addr/wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: assert pio_chipselect for exactly this cycle, with pio_write_n = ~we_l, pio_address = addr_l and pio_writedata = wdata_l. Capture pio_readdata into rdata at the closing edge, for both reads and writes. Go to RESP.
  - RESP: assert ack[grant] for this cycle only. Set last_grant = grant. Go to IDLE.
- Arbitration is round-robin:
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
- Requests and fields are sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS or RESP are ignored.
- A requester that drops req before its ack still completes its transaction: the slave access occurs and ack is pulsed.
- Addresses other than 0 are passed through unchanged. The slave ignores those writes and returns 0 on those reads; the arbiter does not filter them.
- pio_address and pio_writedata hold their latched values outside ACCESS. pio_chipselect is 0 and pio_write_n is 1 outside ACCESS.
- Reset values: state IDLE, last_grant 1, ack 0, rdata 0, busy 0, pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0.
- Reset asserted in any state forces all reset values immediately (asynchronously). An in-flight transaction is abandoned with no ack, and a write in ACCESS is not guaranteed to land.

## Timing
- A req first seen high in IDLE at cycle N produces ACCESS at N+1 and ack at N+2.
- Back-to-back throughput is one access per 3 cycles.
- The requester must drop req (or present a new request) on the edge that closes its ack cycle. The following IDLE cycle samples the updated req, so a held req is treated as a new request.
- Worst-case wait under continuous contention: the other requester's transaction plus one's own. Ack arrives within 5 cycles of req.
- The slave write takes effect on the edge that closes ACCESS. The slave out_port shows the new value from cycle N+2.
- rdata equals the slave's read value during ACCESS, which for address 0 is the pre-write register contents.

## Test plan
- Write, requester 0 alone: after reset, req=01, we=01, addr0=0, wdata0=0xDEADBEEF. Required: chipselect=1 and write_n=0 only at cycle N+1, ack=01 only at N+2, slave out_port=0xDEADBEEF from N+2.
- Read-back, requester 1: slave holds 0x12345678; req=10, we=00, addr1=0. Required: ack=10 at N+2 with rdata=0x12345678, and the slave register unchanged.
- Contention: both requesters hold writes (0x1 from R0, 0x2 from R1) from the same cycle and re-request immediately after each ack. Required grant order R0, R1, R0, R1 and ack every 3 cycles, with no starvation over 20 transactions.
- Unused address: R0 writes 0xFFFFFFFF to addr 2, then reads addr 2. Required: both acked, rdata=0, slave register unchanged.
- Reset during ACCESS: assert reset_n=0 mid-cycle. Required: chipselect=0, write_n=1, ack=00, busy=0 immediately. After release, the first contention goes to R0.
- Early drop: R1 drops req during ACCESS. Required: ack=10 is still pulsed at N+2, then IDLE with no re-grant.
